nor_bus_ctrl: RTL

NOR_BUS_CTRL -- requirements
Module: nor_bus_ctrl

---
 rtl/nor_bus_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/nor_bus_ctrl.sv
// nor_bus_ctrl: Wishbone classic slave to asynchronous parallel NOR flash
// bridge. One 8-bit down-counter times the setup, strobe and hold phases of
// each flash access. All pin and bus outputs are registered.
//
// Optional build macro NOR_BUS_RY_WAIT_EN: when defined, RY/BY# is
// synchronized and a new request is held off while the flash reports busy.
module nor_bus_ctrl #(
  parameter int T_SETUP = 2,
  parameter int T_RD    = 10,
  parameter int T_WR    = 4,
  parameter int T_HOLD  = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [25:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic [25:0] nor_addr_o,
  input  logic [15:0] nor_data_i,
  output logic [15:0] nor_data_o,
  output logic        nor_data_oe,
  output logic        nor_ce_o,
  output logic        nor_oe_o,
  output logic        nor_we_o,
  input  logic        nor_ry_i
);

  localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
  localparam logic [7:0] LD_RD    = 8'(T_RD - 1);
  localparam logic [7:0] LD_WR    = 8'(T_WR - 1);
  localparam logic [7:0] LD_HOLD  = 8'(T_HOLD - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, HOLD, DONE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       we_l;
  logic       ry_ok;

`ifdef NOR_BUS_RY_WAIT_EN
  logic ry_s1, ry_s2;

  // Two-flop synchronizer for the asynchronous RY/BY# pin; idles as ready.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ry_s1 <= 1'b1;
      ry_s2 <= 1'b1;
    end else begin
      ry_s1 <= nor_ry_i;
      ry_s2 <= ry_s1;
    end
  end

  assign ry_ok = ry_s2;
`else
  logic unused_ry;
  assign unused_ry = nor_ry_i;
  assign ry_ok     = 1'b1;
`endif

  // Access sequencer. The ack register also gates acceptance so the request
  // that is being acknowledged is not taken a second time.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      we_l        <= 1'b0;
      nor_ce_o    <= 1'b1;
      nor_oe_o    <= 1'b1;
      nor_we_o    <= 1'b1;
      nor_data_oe <= 1'b0;
      wb_ack_o    <= 1'b0;
      nor_addr_o  <= 26'd0;
      nor_data_o  <= 16'd0;
      wb_dat_o    <= 16'd0;
    end else begin
      wb_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i && !wb_ack_o && ry_ok) begin
            state       <= SETUP;
            nor_ce_o    <= 1'b0;
            nor_addr_o  <= wb_adr_i;
            nor_data_o  <= wb_dat_i;
            we_l        <= wb_we_i;
            nor_data_oe <= wb_we_i;
            cnt         <= LD_SETUP;
          end
        end
        SETUP: begin
          if (cnt == 8'd0) begin
            state <= ACTIVE;
            if (we_l) begin
              nor_we_o <= 1'b0;
              cnt      <= LD_WR;
            end else begin
              nor_oe_o <= 1'b0;
              cnt      <= LD_RD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        ACTIVE: begin
          if (cnt == 8'd0) begin
            state    <= HOLD;
            nor_oe_o <= 1'b1;
            nor_we_o <= 1'b1;
            if (!we_l) wb_dat_o <= nor_data_i;
            cnt      <= LD_HOLD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (cnt == 8'd0) state <= DONE;
          else             cnt   <= cnt - 8'd1;
        end
        DONE: begin
          state       <= IDLE;
          nor_ce_o    <= 1'b1;
          nor_data_oe <= 1'b0;
          wb_ack_o    <= wb_cyc_i;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
